// File: rtl/hex_display_pkg.sv
// Shared types and constants for the hex display controller.
//   state_e   : update sequencer states (IDLE, SCAN, COMMIT)
//   SEG_BLANK : active-low pattern with every segment and the DP off
//   DP_BIT    : bit position of the decimal point within a digit byte
package hex_display_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      COMMIT
   } state_e;

   localparam logic [7:0]  SEG_BLANK = 8'hFF;
   localparam int unsigned DP_BIT    = 7;

endpackage

// File: rtl/hex_display_ctrl_seg.sv
// Combinational hex-to-seven-segment decoder, active-low outputs.
//   hex_i [3:0] : nibble to display (0..F)
//   dot_i       : decimal point enable, active-high
//   seg_o [7:0] : segments {dp,g,f,e,d,c,b,a}, active-low
module hex_display_ctrl_seg (
   input  logic [3:0] hex_i,
   input  logic       dot_i,
   output logic [7:0] seg_o
);

   logic [6:0] gfedcba;

   always_comb begin
      gfedcba = 7'h7F;
      unique case (hex_i)
         4'h0: gfedcba = 7'h40;
         4'h1: gfedcba = 7'h79;
         4'h2: gfedcba = 7'h24;
         4'h3: gfedcba = 7'h30;
         4'h4: gfedcba = 7'h19;
         4'h5: gfedcba = 7'h12;
         4'h6: gfedcba = 7'h02;
         4'h7: gfedcba = 7'h78;
         4'h8: gfedcba = 7'h00;
         4'h9: gfedcba = 7'h10;
         4'hA: gfedcba = 7'h08;
         4'hB: gfedcba = 7'h03;
         4'hC: gfedcba = 7'h46;
         4'hD: gfedcba = 7'h21;
         4'hE: gfedcba = 7'h06;
         4'hF: gfedcba = 7'h0E;
         default: gfedcba = 7'h7F;
      endcase
   end

   assign seg_o = {~dot_i, gfedcba};

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit active-low seven-segment controller.
//   clk, rst_n : clock, asynchronous active-low reset
//   load/ready : update handshake; value/dots/blank_lz sampled on load && ready
//   value      : NDIG hex nibbles, digit 0 least significant
//   dots       : per-digit decimal point enable
//   blank_lz   : leading-zero blanking enable
//   blink_en   : live per-digit blink enable
//   HEX        : registered segments, digit i on HEX[8i+7:8i], bit 7 = DP
// One shared decoder is time-multiplexed over the digits into staging
// registers; the committed registers only change in the single COMMIT cycle.
module hex_display_ctrl
   import hex_display_pkg::*;
#(
   parameter int unsigned NDIG      = 6,
   parameter int unsigned BLINK_DIV = 25_000_000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   output logic                ready,
   input  logic [4*NDIG-1:0]   value,
   input  logic [NDIG-1:0]     dots,
   input  logic                blank_lz,
   input  logic [NDIG-1:0]     blink_en,
   output logic [8*NDIG-1:0]   HEX
);

   localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam int unsigned CW = $clog2(BLINK_DIV);

   state_e                     state_q, state_d;
   logic [IW-1:0]              idx_q, idx_d;
   logic                       seen_nz_q, seen_nz_d;
   logic [NDIG-1:0][3:0]       value_q, value_d;
   logic [NDIG-1:0]            dots_q, dots_d;
   logic                       blank_lz_q, blank_lz_d;
   logic [NDIG-1:0][7:0]       stage_q, stage_d;
   logic [NDIG-1:0][7:0]       commit_q, commit_d;
   logic [NDIG-1:0][7:0]       hex_q, hex_d;
   logic [CW-1:0]              blink_cnt_q;
   logic                       phase_q;

   logic [3:0]                 nib;
   logic [7:0]                 seg_out;
   logic [7:0]                 digit;

   assign nib = value_q[idx_q];

   hex_display_ctrl_seg u_seg (
      .hex_i (nib),
      .dot_i (1'b0),
      .seg_o (seg_out)
   );

   assign ready = (state_q == IDLE);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      seen_nz_d  = seen_nz_q;
      value_d    = value_q;
      dots_d     = dots_q;
      blank_lz_d = blank_lz_q;
      stage_d    = stage_q;
      commit_d   = commit_q;
      digit      = SEG_BLANK;
      unique case (state_q)
         IDLE: begin
            if (load) begin
               value_d    = value;
               dots_d     = dots;
               blank_lz_d = blank_lz;
               idx_d      = IW'(NDIG - 1);
               seen_nz_d  = 1'b0;
               state_d    = SCAN;
            end
         end
         SCAN: begin
            // Scanning runs from the most significant digit down, so seen_nz
            // is exactly "some higher digit was non-zero".
            if (blank_lz_q && !seen_nz_q && (nib == 4'h0) && (idx_q != '0))
               digit = SEG_BLANK;
            else
               digit = seg_out;
            if (dots_q[idx_q])
               digit[DP_BIT] = 1'b0;
            stage_d[idx_q] = digit;
            seen_nz_d      = seen_nz_q | (nib != 4'h0);
            if (idx_q == '0)
               state_d = COMMIT;
            else
               idx_d = idx_q - 1'b1;
         end
         COMMIT: begin
            commit_d = stage_q;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      hex_d = '1;
      for (int unsigned i = 0; i < NDIG; i++)
         hex_d[i] = (phase_q && blink_en[i]) ? SEG_BLANK : commit_q[i];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         seen_nz_q  <= 1'b0;
         value_q    <= '0;
         dots_q     <= '0;
         blank_lz_q <= 1'b0;
         stage_q    <= '1;
         commit_q   <= '1;
         hex_q      <= '1;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         seen_nz_q  <= seen_nz_d;
         value_q    <= value_d;
         dots_q     <= dots_d;
         blank_lz_q <= blank_lz_d;
         stage_q    <= stage_d;
         commit_q   <= commit_d;
         hex_q      <= hex_d;
      end
   end

   // Free-running blink timebase, deliberately untouched by updates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else if (blink_cnt_q == CW'(BLINK_DIV - 1)) begin
         blink_cnt_q <= '0;
         phase_q     <= ~phase_q;
      end else begin
         blink_cnt_q <= blink_cnt_q + 1'b1;
      end
   end

   assign HEX = hex_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;

   localparam int unsigned NDIG = 6;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               load = 1'b0;
   logic               ready;
   logic [4*NDIG-1:0]  value = '0;
   logic [NDIG-1:0]    dots = '0;
   logic               blank_lz = 1'b0;
   logic [NDIG-1:0]    blink_en = '0;
   logic [8*NDIG-1:0]  HEX;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [47:0] exp_hex = '1;

   hex_display_ctrl #(.NDIG(6), .BLINK_DIV(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .ready    (ready),
      .value    (value),
      .dots     (dots),
      .blank_lz (blank_lz),
      .blink_en (blink_en),
      .HEX      (HEX)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one update and follow it through busy, hold and display phases.
   task automatic run_update(input string tag, input logic [23:0] v, input logic [5:0] d,
                             input logic b, input logic [47:0] exp_new);
      int unsigned w = 0;
      @(negedge clk);
      while (!ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      check({tag, "_idle"}, {47'b0, ready}, 48'd1);
      value = v; dots = d; blank_lz = b; load = 1'b1;
      @(posedge clk);                        // T0
      #1 load = 1'b0;
      value = 24'($urandom); dots = 6'($urandom); blank_lz = 1'($urandom);
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         check({tag, "_busy"}, {47'b0, ready}, 48'd0);
         check({tag, "_hold"}, HEX, exp_hex);
      end
      @(negedge clk);                        // after T0+7
      check({tag, "_rdy_back"}, {47'b0, ready}, 48'd1);
      check({tag, "_hold_last"}, HEX, exp_hex);
      @(negedge clk);                        // after T0+8
      check({tag, "_show"}, HEX, exp_new);
      exp_hex = exp_new;
   endtask

   initial begin
      logic [7:0] prev, cur, other, expd;
      int unsigned w;

      // Reset state
      #12;
      check("rst_hex", HEX, 48'hFFFF_FFFF_FFFF);
      check("rst_ready", {47'b0, ready}, 48'd1);
      @(negedge clk) rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("idle_hex", HEX, 48'hFFFF_FFFF_FFFF);
         check("idle_ready", {47'b0, ready}, 48'd1);
      end

      run_update("plain", 24'h12AB0F, 6'b000000, 1'b0, 48'hF9A4_8883_C08E);
      run_update("lz42",  24'h000042, 6'b000000, 1'b1, 48'hFFFF_FFFF_99A4);
      run_update("lz0",   24'h000000, 6'b000000, 1'b1, 48'hFFFF_FFFF_FFC0);
      run_update("lzdot", 24'h000000, 6'b100001, 1'b1, 48'h7FFF_FFFF_FF40);
      run_update("seven", 24'h000007, 6'b000000, 1'b0, 48'hC0C0_C0C0_C0F8);

      // Blink on digit 0: find a phase edge, then expect runs of exactly 4.
      @(negedge clk) blink_en = 6'b000001;
      @(negedge clk);
      prev = HEX[7:0];
      w = 0;
      @(negedge clk);
      while (HEX[7:0] == prev && w < 10) begin
         @(negedge clk);
         w++;
      end
      check("blink_edge_found", {47'b0, (w < 10)}, 48'd1);
      cur = HEX[7:0];
      other = (cur == 8'hFF) ? 8'hF8 : 8'hFF;
      check("blink_value_set", {47'b0, (cur == 8'hFF || cur == 8'hF8)}, 48'd1);
      for (int j = 0; j < 12; j++) begin
         if (j != 0) @(negedge clk);
         expd = (((j / 4) % 2) == 0) ? cur : other;
         check("blink_d0", {40'b0, HEX[7:0]}, {40'b0, expd});
         check("blink_others", {8'b0, HEX[47:8]}, {8'b0, 40'hC0C0_C0C0_C0});
      end
      @(negedge clk) blink_en = '0;
      @(negedge clk);
      @(negedge clk);
      check("blink_off", HEX, 48'hC0C0_C0C0_C0C0 | 48'h0000_0000_0038);

      // load held high with a new value during a scan
      @(negedge clk);
      value = 24'h345678; dots = '0; blank_lz = 1'b0; load = 1'b1;
      @(posedge clk);                        // T0: first accept
      #1 value = 24'h9ABCDE;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         check("held_busy", {47'b0, ready}, 48'd0);
      end
      @(negedge clk);                        // after T0+7: ready, load still high
      check("held_rdy", {47'b0, ready}, 48'd1);
      @(posedge clk);                        // T0+8: second accept
      #1 load = 1'b0;
      @(negedge clk);
      check("held_first_shown", HEX, 48'hB099_9282_F880);
      check("held_second_busy", {47'b0, ready}, 48'd0);
      repeat (7) @(negedge clk);
      check("held_old_kept", HEX, 48'hB099_9282_F880);
      @(negedge clk);
      check("held_second_shown", HEX, 48'h9088_83C6_A186);
      exp_hex = 48'h9088_83C6_A186;

      // Asynchronous reset in the middle of a scan
      @(negedge clk);
      value = 24'h111111; dots = '0; blank_lz = 1'b0; load = 1'b1;
      @(posedge clk);                        // T0
      #1 load = 1'b0;
      repeat (3) @(posedge clk);             // T0+3
      #1 rst_n = 1'b0;
      #1;
      check("abort_hex", HEX, 48'hFFFF_FFFF_FFFF);
      check("abort_ready", {47'b0, ready}, 48'd1);
      @(negedge clk) rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("abort_stays_blank", HEX, 48'hFFFF_FFFF_FFFF);
      check("abort_ready_after", {47'b0, ready}, 48'd1);
      exp_hex = 48'hFFFF_FFFF_FFFF;
      run_update("after_abort", 24'h12AB0F, 6'b000000, 1'b0, 48'hF9A4_8883_C08E);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Controller that drives a bank of NDIG active-low seven-segment digits from one packed hex value by time-sharing a single SEG decoder instance. Accepts a new value and per-digit dot, blanking and blink controls through a valid/ready handshake. Scans the digits once per update into staging registers and commits them atomically, so the display never shows a mix of old and new values. Sits between the application datapath and the board HEX pins.

## Interface
- NDIG, 6: number of digits, valid range 1..8.
- BLINK_DIV, 25_000_000: clock cycles per blink half-period, minimum 2.
- clk  in  1  system clock; one clock domain, all logic on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- load  in  1  update request; the update is accepted on the edge where load && ready.
- ready  out  1  high when idle and able to accept load.
- value  in  4*NDIG  hex nibbles; digit i is value[4i+3:4i]; digit 0 is least significant.
- dots  in  NDIG  dot enable per digit, active-high.
- blank_lz  in  1  leading-zero blanking enable.
- blink_en  in  NDIG  blink enable per digit; live input, not latched.
- HEX  out  8*NDIG  segments for digit i on HEX[8i+7:8i]; active-low; bit 7 = DP.

## Operation
- States: IDLE, SCAN, COMMIT. ready = (state == IDLE).
- IDLE: on load && ready, latch value, dots and blank_lz into shadow registers. Set idx = NDIG-1, clear seen_nz, go to SCAN.
- SCAN: each cycle, feed shadow nibble[idx] to the shared SEG decoder.
  - Write staging[idx] from the decoder output, with bit 7 cleared when dots[idx] = 1.
  - Digit idx is blanked (8'hFF before the dot is applied) when blank_lz && !seen_nz && nibble == 0 && idx != 0.
  - Set seen_nz when nibble != 0.
  - Decrement idx. When idx == 0 is processed, go to COMMIT.
- COMMIT: copy staging into the committed registers in one cycle, then go to IDLE.
- Digit 0 is never blanked, so value 0 always shows "0".
- A blanked digit still shows its DP when its dot bit is set (8'h7F).
- Blink: a free-running counter runs 0..BLINK_DIV-1 and wraps to 0; phase toggles on each wrap.
  - When phase = 1, digits with blink_en[i] = 1 output 8'hFF.
  - Otherwise each digit outputs its committed value.
- HEX is registered each cycle from the committed registers with the blink mask applied.
- load while ready = 0 is ignored and not queued. The requester holds load and its data until accepted.
- value, dots and blank_lz are don't-care except on the accept edge.

## Timing
- Reset values:
  - HEX = all 8'hFF; ready = 1; state IDLE.
  - Committed and staging registers = 8'hFF; blink counter = 0; phase = 0.
- rst_n low mid-SCAN or mid-COMMIT aborts the update immediately (asynchronous). The display returns to blank and the partial update is discarded.
- Accept at edge T0. SCAN occupies edges T0+1..T0+NDIG. COMMIT completes at edge T0+NDIG+1, when ready returns high.
- ready is low for exactly NDIG+1 cycles.
- The new value appears on HEX at edge T0+NDIG+2. The old value is held on HEX until then.
- A back-to-back load is accepted on the first cycle ready is high again.
- The blink phase is independent of updates. A commit does not reset the blink counter.

## Structure
- Package hex_display_pkg holds:
  - the state enum (IDLE, SCAN, COMMIT);
  - SEG_BLANK = 8'hFF;
  - DP_BIT = 7.
- One sub-module: the existing SEG decoder, instantiated exactly once as the shared decoder. Its dot input is tied to 0; DP handling is done in this block.
- Index counter width: $clog2(NDIG), minimum 1 bit.

## Test plan
Bench parameters: NDIG = 6, BLINK_DIV = 4.
- Reset with load = 0 → HEX = 48'hFFFF_FFFF_FFFF and ready = 1. Hold 20 cycles and confirm no change.
- load value = 24'h12AB0F, dots = 0, blank_lz = 0 →
  - ready is low for 7 cycles;
  - at T0+8, digits 5..0 = F9, A4, 88, 83, C0, 8E.
- blank_lz = 1:
  - value 24'h000042 → digits 5..2 = FF, digit 1 = 99, digit 0 = A4;
  - value 0 → digits 5..1 = FF, digit 0 = C0.
- value 0, blank_lz = 1, dots = 6'b100001 → digit 5 = 7F, digit 0 = 40, the rest = FF.
- blink_en = 6'b000001 after value 24'h000007 → digit 0 alternates F8 and FF every 4 cycles; the other digits stay constant.
- Robustness:
  - Hold load high with a new value during a scan → the update is ignored until ready, then accepted and displayed.
  - Pull rst_n low at T0+3 → HEX = all FF immediately and ready = 1 after release.
